// File: rtl/pkt_ingress.sv
// Packet ingress: collects the leading bytes of each packet into a parallel
// header buffer, hands it to the processor and waits for completion.
module pkt_ingress #(
  parameter int HDR_MAX_LEN = 64,
  parameter int LEN_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid_i,
  input  logic [7:0]                    in_data_i,
  input  logic                          in_last_i,
  output logic                          in_ready_o,
  output logic [HDR_MAX_LEN-1:0][7:0]   pkt_hdr_o,
  output logic                          proc_start_o,
  input  logic                          proc_ready_i,
  output logic [LEN_W-1:0]              pkt_len_o,
  output logic                          trunc_o,
  output logic                          done_o,
  output logic [31:0]                   pkt_cnt_o
);

  localparam logic [1:0] S_RECV    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]                  r_state;
  logic                        r_in_ready;
  logic                        r_start;
  logic [LEN_W-1:0]            r_byte_cnt;
  logic                        r_trunc_flag;
  logic [LEN_W-1:0]            r_len_lat;
  logic                        r_trunc_lat;
  logic [LEN_W-1:0]            r_pkt_len;
  logic                        r_trunc;
  logic                        r_done;
  logic [31:0]                 r_pkt_cnt;
  logic [HDR_MAX_LEN-1:0][7:0] r_hdr;

  logic                        w_accept;
  logic                        w_over;
  logic [LEN_W-1:0]            w_cnt_inc;
  logic [HDR_MAX_LEN-1:0]      w_wr_en;

  assign w_accept  = in_valid_i && r_in_ready && (r_state == S_RECV);
  assign w_over    = (r_byte_cnt >= LEN_W'(HDR_MAX_LEN));
  assign w_cnt_inc = (&r_byte_cnt) ? r_byte_cnt : r_byte_cnt + 1'b1;

  // The byte counter doubles as the write pointer; it never matches a
  // buffer slot once it has run past the header window.
  generate
    for (genvar gi = 0; gi < HDR_MAX_LEN; gi++) begin : g_wr_en
      assign w_wr_en[gi] = w_accept && (r_byte_cnt == LEN_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || (r_state == S_RELEASE)) begin
      r_hdr <= '0;
    end else begin
      for (int i = 0; i < HDR_MAX_LEN; i++) begin
        if (w_wr_en[i]) r_hdr[i] <= in_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RELEASE;
      r_in_ready   <= 1'b0;
      r_start      <= 1'b0;
      r_byte_cnt   <= '0;
      r_trunc_flag <= 1'b0;
      r_len_lat    <= '0;
      r_trunc_lat  <= 1'b0;
      r_pkt_len    <= '0;
      r_trunc      <= 1'b0;
      r_done       <= 1'b0;
      r_pkt_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RECV: begin
          if (w_accept) begin
            r_byte_cnt <= w_cnt_inc;
            if (w_over) r_trunc_flag <= 1'b1;
            if (in_last_i) begin
              r_len_lat   <= w_cnt_inc;
              r_trunc_lat <= r_trunc_flag | w_over;
              r_in_ready  <= 1'b0;
              r_start     <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
        end
        // proc_ready_i may still be high from the previous packet here.
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (proc_ready_i) begin
            r_start   <= 1'b0;
            r_done    <= 1'b1;
            r_pkt_len <= r_len_lat;
            r_trunc   <= r_trunc_lat;
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
            r_state   <= S_RELEASE;
          end
        end
        default: begin
          r_byte_cnt   <= '0;
          r_trunc_flag <= 1'b0;
          r_in_ready   <= 1'b1;
          r_start      <= 1'b0;
          r_state      <= S_RECV;
        end
      endcase
    end
  end

  assign in_ready_o   = r_in_ready;
  assign pkt_hdr_o    = r_hdr;
  assign proc_start_o = r_start;
  assign pkt_len_o    = r_pkt_len;
  assign trunc_o      = r_trunc;
  assign done_o       = r_done;
  assign pkt_cnt_o    = r_pkt_cnt;

endmodule

// File: tb/tb_pkt_ingress.sv
// Bench for pkt_ingress: directed and random packets against a queue-based
// model of the header buffer, length, truncation and packet count.
module tb_pkt_ingress;
  localparam int HDR = 64;
  localparam int LW  = 16;
  typedef logic [HDR-1:0][7:0] hdr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid_i = 1'b0;
  logic [7:0]    in_data_i = 8'h00;
  logic          in_last_i = 1'b0;
  logic          proc_ready_i = 1'b0;
  logic          in_ready_o;
  hdr_t          pkt_hdr_o;
  logic          proc_start_o;
  logic [LW-1:0] pkt_len_o;
  logic          trunc_o;
  logic          done_o;
  logic [31:0]   pkt_cnt_o;

  pkt_ingress #(.HDR_MAX_LEN(HDR), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_last_i(in_last_i),
    .in_ready_o(in_ready_o), .pkt_hdr_o(pkt_hdr_o),
    .proc_start_o(proc_start_o), .proc_ready_i(proc_ready_i),
    .pkt_len_o(pkt_len_o), .trunc_o(trunc_o), .done_o(done_o),
    .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  byte unsigned  pkt_q[$];
  logic [31:0]   exp_cnt = 0;
  logic [LW-1:0] exp_len = '0;
  logic          exp_trunc = 1'b0;
  logic [LW-1:0] pend_len = '0;
  logic          pend_trunc = 1'b0;
  hdr_t          zero_hdr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hdr(input string tag, input hdr_t obs, input hdr_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected buffer: first HDR bytes of the packet, zeros past its end.
  function automatic hdr_t model_hdr();
    hdr_t h = '0;
    for (int i = 0; i < HDR; i++)
      if (i < pkt_q.size()) h[i] = pkt_q[i];
    return h;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int len, input bit ramp);
    int guard = 0;
    pkt_q.delete();
    while (!in_ready_o && guard < 50) begin
      step();
      guard++;
    end
    chk("rdy_wait", 32'(in_ready_o), 32'd1);
    for (int i = 0; i < len; i++) begin
      byte unsigned b;
      b = ramp ? 8'(i + 1) : 8'($urandom);
      pkt_q.push_back(b);
      if (!ramp && $urandom_range(0, 3) == 0) begin
        in_valid_i = 1'b0;
        in_data_i  = 8'($urandom);
        in_last_i  = 1'($urandom);
        step();
      end
      in_valid_i = 1'b1;
      in_data_i  = b;
      in_last_i  = (i == len - 1);
      step();
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    pend_len   = (len > 65535) ? LW'(65535) : LW'(len);
    pend_trunc = (len > HDR);
    chk("start_at_last", 32'(proc_start_o), 32'd1);
    chk("rdy_low_at_last", 32'(in_ready_o), 32'd0);
  endtask

  // Plays the processor: optional stale ready through ISSUE, then `delay`
  // WAIT cycles with ready low before completing.
  task automatic run_proc(input int delay, input bit stale, input bit hold_valid, input bit keep_ready);
    hdr_t eh = model_hdr();
    proc_ready_i = stale;
    if (hold_valid) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'($urandom);
      in_last_i  = 1'b1;
    end
    step();
    chk("issue_no_done", 32'(done_o), 32'd0);
    chk("issue_start", 32'(proc_start_o), 32'd1);
    proc_ready_i = 1'b0;
    for (int d = 0; d < delay; d++) begin
      step();
      chk("wait_no_done", 32'(done_o), 32'd0);
      chk("wait_start", 32'(proc_start_o), 32'd1);
      chk("wait_rdy_low", 32'(in_ready_o), 32'd0);
      chk_hdr("wait_hdr", pkt_hdr_o, eh);
      if (hold_valid) in_data_i = 8'($urandom);
    end
    proc_ready_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    exp_cnt   = exp_cnt + 32'd1;
    exp_len   = pend_len;
    exp_trunc = pend_trunc;
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("start_drop", 32'(proc_start_o), 32'd0);
    chk("pkt_len", 32'(pkt_len_o), 32'(exp_len));
    chk("trunc", 32'(trunc_o), 32'(exp_trunc));
    chk("pkt_cnt", pkt_cnt_o, exp_cnt);
    chk_hdr("hdr_at_done", pkt_hdr_o, eh);
    if (!keep_ready) proc_ready_i = 1'b0;
    step();
    chk("done_single", 32'(done_o), 32'd0);
    chk("rdy_after_rel", 32'(in_ready_o), 32'd1);
    chk_hdr("hdr_cleared", pkt_hdr_o, zero_hdr);
    chk("len_hold", 32'(pkt_len_o), 32'(exp_len));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    step();
    step();
    chk("rst_rdy", 32'(in_ready_o), 32'd0);
    chk("rst_start", 32'(proc_start_o), 32'd0);
    chk("rst_len", 32'(pkt_len_o), 32'd0);
    chk("rst_trunc", 32'(trunc_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cnt", pkt_cnt_o, 32'd0);
    chk_hdr("rst_hdr", pkt_hdr_o, zero_hdr);
    rst = 1'b0;
    step();
    chk("post_rst_rdy", 32'(in_ready_o), 32'd1);

    // 14-byte ramp, ready 5 cycles after start; ready then left high
    send_pkt(14, 1'b1);
    run_proc(4, 1'b0, 1'b0, 1'b1);

    // Stale ready carried into packet 2
    send_pkt(20, 1'b0);
    run_proc(3, 1'b1, 1'b0, 1'b0);

    // Truncated packet, then a short one
    send_pkt(100, 1'b0);
    run_proc(2, 1'b0, 1'b0, 1'b0);
    send_pkt(3, 1'b0);
    run_proc(1, 1'b0, 1'b0, 1'b0);

    // Valid held high across WAIT
    send_pkt(9, 1'b0);
    run_proc(6, 1'b0, 1'b1, 1'b0);

    // Single-byte packet
    send_pkt(1, 1'b0);
    run_proc(0, 1'b0, 1'b0, 1'b0);

    // Random packets and processor latencies
    for (int k = 0; k < 8; k++) begin
      send_pkt($urandom_range(1, 90), 1'b0);
      run_proc($urandom_range(0, 6), 1'($urandom), 1'($urandom), 1'b0);
    end

    // Reset while waiting on the processor
    send_pkt(10, 1'b0);
    proc_ready_i = 1'b0;
    step();
    step();
    chk("wait_before_rst", 32'(proc_start_o), 32'd1);
    rst = 1'b1;
    step();
    exp_cnt = 0; exp_len = '0; exp_trunc = 1'b0;
    chk("rstw_start", 32'(proc_start_o), 32'd0);
    chk_hdr("rstw_hdr", pkt_hdr_o, zero_hdr);
    chk("rstw_cnt", pkt_cnt_o, 32'd0);
    chk("rstw_rdy", 32'(in_ready_o), 32'd0);
    rst = 1'b0;
    step();
    chk("rstw_rdy_back", 32'(in_ready_o), 32'd1);
    send_pkt(5, 1'b0);
    run_proc(2, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
